tcdm_port_arbiter: RTL and testbench

TCDM_PORT_ARBITER -- requirements
Module: tcdm_port_arbiter

---
 rtl/tcdm_port_arbiter_pkg.sv | 15 +
 rtl/tcdm_port_arbiter_if.sv | 42 ++++
 rtl/tcdm_port_arbiter_rr_pick.sv | 39 +++
 rtl/tcdm_port_arbiter.sv | 111 +++++++++++
 tb/tb_tcdm_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_port_arbiter_pkg.sv
// rtl/tcdm_port_arbiter_pkg.sv - TCDM bus width constants and request bundle type
package pkg_soc_interconnect;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } tcdm_req_t;

endpackage

// File: rtl/tcdm_port_arbiter_if.sv
// rtl/tcdm_port_arbiter_if.sv - bundle of master-side and slave-side TCDM arbiter signals
interface tcdm_port_arbiter_if
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned NR_MASTER_PORTS = 4
) ();

  logic [NR_MASTER_PORTS-1:0]                 master_req;
  logic [NR_MASTER_PORTS-1:0][ADDR_WIDTH-1:0] master_add;
  logic [NR_MASTER_PORTS-1:0]                 master_wen;
  logic [NR_MASTER_PORTS-1:0][DATA_WIDTH-1:0] master_wdata;
  logic [NR_MASTER_PORTS-1:0][BE_WIDTH-1:0]   master_be;
  logic [NR_MASTER_PORTS-1:0]                 master_gnt;
  logic [NR_MASTER_PORTS-1:0]                 master_r_valid;
  logic [DATA_WIDTH-1:0]                      master_r_rdata;
  logic                                       master_r_opc;

  logic                  slave_req;
  logic [ADDR_WIDTH-1:0] slave_add;
  logic                  slave_wen;
  logic [DATA_WIDTH-1:0] slave_wdata;
  logic [BE_WIDTH-1:0]   slave_be;
  logic                  slave_gnt;
  logic [DATA_WIDTH-1:0] slave_r_rdata;
  logic                  slave_r_opc;

  // Environment view: drives master requests and the shared slave's answers.
  modport master (
    output master_req, master_add, master_wen, master_wdata, master_be,
    output slave_gnt, slave_r_rdata, slave_r_opc,
    input  master_gnt, master_r_valid, master_r_rdata, master_r_opc,
    input  slave_req, slave_add, slave_wen, slave_wdata, slave_be
  );

  modport slave (
    input  master_req, master_add, master_wen, master_wdata, master_be,
    input  slave_gnt, slave_r_rdata, slave_r_opc,
    output master_gnt, master_r_valid, master_r_rdata, master_r_opc,
    output slave_req, slave_add, slave_wen, slave_wdata, slave_be
  );

endinterface

// File: rtl/tcdm_port_arbiter_rr_pick.sv
// rtl/tcdm_port_arbiter_rr_pick.sv - hold-aware round-robin winner selection
module tcdm_rr_pick #(
  parameter int unsigned NR_PORTS = 4,
  parameter int unsigned IDX_W    = $clog2(NR_PORTS)
) (
  input  logic [NR_PORTS-1:0] req,
  input  logic [IDX_W-1:0]    start_ptr,
  input  logic [IDX_W-1:0]    owner,
  input  logic                owner_hold,
  output logic [IDX_W-1:0]    idx,
  output logic                valid
);

  logic [IDX_W:0] pos;

  // The scan covers all ports and ends on the owner itself, so a sole
  // requesting owner keeps winning even once its hold budget is spent.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    pos   = '0;
    if (owner_hold && req[owner]) begin
      idx   = owner;
      valid = 1'b1;
    end else begin
      for (int unsigned i = 0; i < NR_PORTS; i++) begin
        pos = {1'b0, start_ptr} + (IDX_W+1)'(i);
        if (pos >= (IDX_W+1)'(NR_PORTS)) begin
          pos = pos - (IDX_W+1)'(NR_PORTS);
        end
        if (!valid && req[pos[IDX_W-1:0]]) begin
          idx   = pos[IDX_W-1:0];
          valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tcdm_port_arbiter.sv
// rtl/tcdm_port_arbiter.sv - N-to-1 TCDM arbiter with bounded-hold round-robin and 1-cycle responses
module tcdm_port_arbiter
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned NR_MASTER_PORTS = 4,
  parameter int unsigned MAX_HOLD        = 4
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NR_MASTER_PORTS-1:0]                 master_req_i,
  input  logic [NR_MASTER_PORTS-1:0][ADDR_WIDTH-1:0] master_add_i,
  input  logic [NR_MASTER_PORTS-1:0]                 master_wen_i,
  input  logic [NR_MASTER_PORTS-1:0][DATA_WIDTH-1:0] master_wdata_i,
  input  logic [NR_MASTER_PORTS-1:0][BE_WIDTH-1:0]   master_be_i,
  output logic [NR_MASTER_PORTS-1:0]                 master_gnt_o,
  output logic [NR_MASTER_PORTS-1:0]                 master_r_valid_o,
  output logic [DATA_WIDTH-1:0]                      master_r_rdata_o,
  output logic                                       master_r_opc_o,
  output logic                                       slave_req_o,
  output logic [ADDR_WIDTH-1:0]                      slave_add_o,
  output logic                                       slave_wen_o,
  output logic [DATA_WIDTH-1:0]                      slave_wdata_o,
  output logic [BE_WIDTH-1:0]                        slave_be_o,
  input  logic                                       slave_gnt_i,
  input  logic [DATA_WIDTH-1:0]                      slave_r_rdata_i,
  input  logic                                       slave_r_opc_i
);

  localparam int unsigned IDX_W  = $clog2(NR_MASTER_PORTS);
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  start_ptr;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  resp_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              win_valid;
  logic              owner_hold;
  logic              resp_pending;
  logic              handshake;
  tcdm_req_t         sel;

  assign start_ptr = (owner == IDX_W'(NR_MASTER_PORTS - 1)) ? '0 : owner + 1'b1;
  // hold_cnt == 0 means nobody has been granted since reset, so the reset
  // owner gets no hold privilege and master 0 is found first.
  assign owner_hold = (hold_cnt != '0) && (hold_cnt < HOLD_W'(MAX_HOLD));

  tcdm_rr_pick #(
    .NR_PORTS (NR_MASTER_PORTS),
    .IDX_W    (IDX_W)
  ) u_pick (
    .req        (master_req_i),
    .start_ptr  (start_ptr),
    .owner      (owner),
    .owner_hold (owner_hold),
    .idx        (win_idx),
    .valid      (win_valid)
  );

  assign slave_req_o = |master_req_i;
  assign handshake   = slave_req_o && slave_gnt_i;

  // win_idx is 0 when nobody requests, so the idle bus shows master 0.
  assign sel = '{
    add:   master_add_i[win_idx],
    wen:   master_wen_i[win_idx],
    wdata: master_wdata_i[win_idx],
    be:    master_be_i[win_idx]
  };

  assign slave_add_o   = sel.add;
  assign slave_wen_o   = sel.wen;
  assign slave_wdata_o = sel.wdata;
  assign slave_be_o    = sel.be;

  always_comb begin
    master_gnt_o          = '0;
    master_gnt_o[win_idx] = win_valid && slave_gnt_i && master_req_i[win_idx];
  end

  always_comb begin
    master_r_valid_o           = '0;
    master_r_valid_o[resp_idx] = resp_pending;
  end

  assign master_r_rdata_o = slave_r_rdata_i;
  assign master_r_opc_o   = slave_r_opc_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner        <= IDX_W'(NR_MASTER_PORTS - 1);
      hold_cnt     <= '0;
      resp_pending <= 1'b0;
      resp_idx     <= '0;
    end else begin
      resp_pending <= handshake;
      if (handshake) begin
        owner    <= win_idx;
        resp_idx <= win_idx;
        if (win_idx == owner) begin
          if (hold_cnt < HOLD_W'(MAX_HOLD)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end else begin
          hold_cnt <= HOLD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_tcdm_port_arbiter.sv
// tb/tb_tcdm_port_arbiter.sv - directed and scoreboarded checks of tcdm_port_arbiter
module tb_tcdm_port_arbiter;
  import pkg_soc_interconnect::*;

  localparam int N  = 4;
  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  tcdm_port_arbiter_if #(.NR_MASTER_PORTS(N)) bus ();

  tcdm_port_arbiter #(
    .NR_MASTER_PORTS (N),
    .MAX_HOLD        (MH)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .master_req_i     (bus.master_req),
    .master_add_i     (bus.master_add),
    .master_wen_i     (bus.master_wen),
    .master_wdata_i   (bus.master_wdata),
    .master_be_i      (bus.master_be),
    .master_gnt_o     (bus.master_gnt),
    .master_r_valid_o (bus.master_r_valid),
    .master_r_rdata_o (bus.master_r_rdata),
    .master_r_opc_o   (bus.master_r_opc),
    .slave_req_o      (bus.slave_req),
    .slave_add_o      (bus.slave_add),
    .slave_wen_o      (bus.slave_wen),
    .slave_wdata_o    (bus.slave_wdata),
    .slave_be_o       (bus.slave_be),
    .slave_gnt_i      (bus.slave_gnt),
    .slave_r_rdata_i  (bus.slave_r_rdata),
    .slave_r_opc_i    (bus.slave_r_opc)
  );

  task automatic idle_inputs();
    bus.master_req = '0;
    for (int i = 0; i < N; i++) begin
      bus.master_add[i]   = 32'h1000_0000 + 32'(i * 16);
      bus.master_wen[i]   = 1'b1;
      bus.master_wdata[i] = 32'hA000_0000 + 32'(i);
      bus.master_be[i]    = 4'hF;
    end
    bus.slave_gnt     = 1'b0;
    bus.slave_r_rdata = '0;
    bus.slave_r_opc   = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    bus.master_req = 4'b1111;
    bus.slave_gnt  = 1'b1;
    next_cycle();
    #3;
    checks++;
    if (bus.master_r_valid !== 4'b0000) $display("FAIL reset_rvalid: got %b want 0000", bus.master_r_valid);
    else passed++;
    next_cycle();
    idle_inputs();
    rst_n = 1'b1;
    #3;
    checks++;
    if (bus.master_gnt !== 4'b0000) $display("FAIL idle_gnt: got %b want 0000", bus.master_gnt);
    else passed++;
    checks++;
    if (bus.slave_req !== 1'b0) $display("FAIL idle_slave_req: got %b want 0", bus.slave_req);
    else passed++;
    checks++;
    if (bus.slave_add !== 32'h1000_0000 || bus.slave_wdata !== 32'hA000_0000)
      $display("FAIL idle_mux_idx0: got add %h wdata %h want 10000000 a0000000", bus.slave_add, bus.slave_wdata);
    else passed++;
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_rv;
    do_reset();
    bus.master_req = 4'b1111;
    bus.slave_gnt  = 1'b1;
    exp_rv = '0;
    for (int i = 0; i < 16; i++) begin
      exp_g = 4'b0001 << (i / 4);
      #3;
      checks++;
      if (bus.master_gnt !== exp_g) $display("FAIL rr_gnt cyc %0d: got %b want %b", i, bus.master_gnt, exp_g);
      else passed++;
      checks++;
      if (bus.master_r_valid !== exp_rv) $display("FAIL rr_rvalid cyc %0d: got %b want %b", i, bus.master_r_valid, exp_rv);
      else passed++;
      checks++;
      if (bus.slave_add !== 32'h1000_0000 + 32'((i / 4) * 16))
        $display("FAIL rr_add cyc %0d: got %h want %h", i, bus.slave_add, 32'h1000_0000 + 32'((i / 4) * 16));
      else passed++;
      exp_rv = exp_g;
      next_cycle();
    end
    bus.master_req = '0;
    #3;
    checks++;
    if (bus.master_r_valid !== 4'b1000) $display("FAIL rr_last_rvalid: got %b want 1000", bus.master_r_valid);
    else passed++;
    next_cycle();
  endtask

  task automatic test_sole_master();
    do_reset();
    bus.master_req = 4'b0100;
    bus.slave_gnt  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #3;
      checks++;
      if (bus.master_gnt !== 4'b0100) $display("FAIL sole_gnt cyc %0d: got %b want 0100", i, bus.master_gnt);
      else passed++;
      checks++;
      if (bus.master_r_valid !== (i == 0 ? 4'b0000 : 4'b0100))
        $display("FAIL sole_rvalid cyc %0d: got %b want %b", i, bus.master_r_valid, (i == 0 ? 4'b0000 : 4'b0100));
      else passed++;
      next_cycle();
    end
    checks++;
    if (dut.hold_cnt !== 3'd4) $display("FAIL sole_hold_cnt: got %0d want 4", dut.hold_cnt);
    else passed++;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_stall();
    do_reset();
    bus.master_req = 4'b1010;
    bus.slave_gnt  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #3;
      checks++;
      if (bus.master_gnt !== 4'b0000 || bus.master_r_valid !== 4'b0000 || bus.slave_req !== 1'b1)
        $display("FAIL stall cyc %0d: got gnt %b rvalid %b req %b want 0000 0000 1", i, bus.master_gnt, bus.master_r_valid, bus.slave_req);
      else passed++;
      next_cycle();
    end
    bus.slave_gnt = 1'b1;
    #3;
    checks++;
    if (bus.master_gnt !== 4'b0010) $display("FAIL stall_first_gnt: got %b want 0010", bus.master_gnt);
    else passed++;
    next_cycle();
    #3;
    checks++;
    if (bus.master_r_valid !== 4'b0010 || bus.master_gnt !== 4'b0010)
      $display("FAIL stall_after: got rvalid %b gnt %b want 0010 0010", bus.master_r_valid, bus.master_gnt);
    else passed++;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_write_read();
    do_reset();
    bus.master_req      = 4'b0001;
    bus.master_wen[0]   = 1'b0;
    bus.master_add[0]   = 32'h1C00_0010;
    bus.master_wdata[0] = 32'hDEAD_BEEF;
    bus.master_be[0]    = 4'hF;
    bus.master_add[1]   = 32'h1C00_0020;
    bus.slave_gnt       = 1'b1;
    #3;
    checks++;
    if (bus.master_gnt !== 4'b0001 || bus.slave_add !== 32'h1C00_0010 || bus.slave_wen !== 1'b0 ||
        bus.slave_wdata !== 32'hDEAD_BEEF || bus.slave_be !== 4'hF)
      $display("FAIL wr_req: got gnt %b add %h wen %b wdata %h be %h want 0001 1c000010 0 deadbeef f",
               bus.master_gnt, bus.slave_add, bus.slave_wen, bus.slave_wdata, bus.slave_be);
    else passed++;
    next_cycle();
    bus.master_req = 4'b0010;
    #3;
    checks++;
    if (bus.master_gnt !== 4'b0010 || bus.slave_add !== 32'h1C00_0020 || bus.slave_wen !== 1'b1)
      $display("FAIL rd_req: got gnt %b add %h wen %b want 0010 1c000020 1", bus.master_gnt, bus.slave_add, bus.slave_wen);
    else passed++;
    checks++;
    if (bus.master_r_valid !== 4'b0001) $display("FAIL wr_resp: got %b want 0001", bus.master_r_valid);
    else passed++;
    next_cycle();
    bus.master_req    = '0;
    bus.slave_r_rdata = 32'h1234_5678;
    bus.slave_r_opc   = 1'b0;
    #3;
    checks++;
    if (bus.master_r_valid !== 4'b0010 || bus.master_r_rdata !== 32'h1234_5678 || bus.master_r_opc !== 1'b0)
      $display("FAIL rd_resp: got rvalid %b rdata %h opc %b want 0010 12345678 0",
               bus.master_r_valid, bus.master_r_rdata, bus.master_r_opc);
    else passed++;
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    bus.master_req = 4'b1000;
    bus.slave_gnt  = 1'b1;
    #3;
    checks++;
    if (bus.master_gnt !== 4'b1000) $display("FAIL inflight_gnt: got %b want 1000", bus.master_gnt);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.master_r_valid !== 4'b0000) $display("FAIL inflight_rvalid_a: got %b want 0000", bus.master_r_valid);
    else passed++;
    next_cycle();
    checks++;
    if (bus.master_r_valid !== 4'b0000) $display("FAIL inflight_rvalid_b: got %b want 0000", bus.master_r_valid);
    else passed++;
    next_cycle();
    rst_n = 1'b1;
    bus.master_req = 4'b1111;
    #3;
    checks++;
    if (bus.master_gnt !== 4'b0001 || bus.master_r_valid !== 4'b0000)
      $display("FAIL post_reset: got gnt %b rvalid %b want 0001 0000", bus.master_gnt, bus.master_r_valid);
    else passed++;
    next_cycle();
    #3;
    checks++;
    if (bus.master_r_valid !== 4'b0001) $display("FAIL post_reset_rvalid: got %b want 0001", bus.master_r_valid);
    else passed++;
    idle_inputs();
    next_cycle();
  endtask

  function automatic int model_pick(logic [N-1:0] r, int own, int hold);
    if (hold != 0 && hold < MH && r[own]) return own;
    for (int k = 1; k <= N; k++) begin
      if (r[(own + k) % N]) return (own + k) % N;
    end
    return -1;
  endfunction

  task automatic test_random();
    int m_owner = N - 1;
    int m_hold  = 0;
    int w;
    int fails_shown = 0;
    int fair_viol = 0;
    int waits[N];
    logic [N-1:0] req_v = '0;
    logic [N-1:0] last_g = '0;
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_rv = '0;
    logic sg;
    do_reset();
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_v[i] && !last_g[i])) req_v[i] = ($urandom_range(0, 1) == 1);
      end
      sg = ($urandom_range(0, 3) != 0);
      bus.master_req = req_v;
      bus.slave_gnt  = sg;
      bus.slave_r_rdata = $urandom;
      w = model_pick(req_v, m_owner, m_hold);
      exp_g = '0;
      if (w >= 0 && sg) exp_g[w] = 1'b1;
      #3;
      checks++;
      if (bus.master_gnt !== exp_g || bus.master_r_valid !== exp_rv) begin
        if (fails_shown < 10) $display("FAIL rand cyc %0d: got gnt %b rvalid %b want %b %b",
                                       c, bus.master_gnt, bus.master_r_valid, exp_g, exp_rv);
        fails_shown++;
      end else passed++;
      for (int i = 0; i < N; i++) begin
        if (exp_g[i] || !req_v[i]) waits[i] = 0;
        else if (exp_g != '0) begin
          waits[i]++;
          if (waits[i] > (N - 1) * MH) fair_viol++;
        end
      end
      if (exp_g != '0) begin
        if (w == m_owner) m_hold = (m_hold < MH) ? m_hold + 1 : MH;
        else m_hold = 1;
        m_owner = w;
      end
      exp_rv = exp_g;
      last_g = exp_g;
      next_cycle();
    end
    checks++;
    if (fair_viol != 0) $display("FAIL rand_fairness: got %0d violations want 0", fair_viol);
    else passed++;
    idle_inputs();
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_sole_master();
    test_stall();
    test_write_read();
    test_reset_in_flight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
